// File: rtl/pipelined_prefix_adder.sv
// Segmented Kogge-Stone add/subtract with a pipeline register every STAGE_LVLS prefix levels.
// Define PPA_FLAGS_EN to add the registered out_zero / out_ovf result flags.
module pipelined_prefix_adder #(
  parameter int WIDTH      = 128,
  parameter int SEG_W      = 64,
  parameter int STAGE_LVLS = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic             in_cin,
  input  logic             in_sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_sum,
  output logic             out_cout
`ifdef PPA_FLAGS_EN
  ,
  output logic             out_zero,
  output logic             out_ovf
`endif
);

  localparam int L    = $clog2(WIDTH);
  localparam int S    = $clog2(SEG_W);
  localparam int NS   = WIDTH / SEG_W;
  localparam int CL   = (NS > 1) ? $clog2(NS) - 1 : 0;
  localparam int HALF = NS / 2;
  localparam int SL   = (STAGE_LVLS > 0) ? STAGE_LVLS : 1;

  logic             adv;
  logic [WIDTH-1:0] g_src    [0:L];
  logic [WIDTH-1:0] p_src    [0:L];
  logic [WIDTH-1:0] prop_src [0:L];
  logic             c0_src   [0:L];
  logic             valid_src[0:L];

  assign adv      = out_ready | ~out_valid;
  assign in_ready = adv;

  logic [WIDTH-1:0] b_eff;
  logic [WIDTH-1:0] p0;
  logic             c0;

  always_comb begin
    b_eff = in_sub ? ~in_b : in_b;
    c0    = in_sub | in_cin;
    p0    = in_a ^ b_eff;
  end

  // c0 is folded into the bit-0 generate so group generates become carries directly
  assign g_src[0]     = (in_a & b_eff) | {{(WIDTH-1){1'b0}}, p0[0] & c0};
  assign p_src[0]     = p0;
  assign prop_src[0]  = p0;
  assign c0_src[0]    = c0;
  assign valid_src[0] = in_valid & in_ready;

  for (genvar gi = 1; gi <= L; gi++) begin : g_lvl
    localparam bit REG_HERE = (STAGE_LVLS > 0) && ((gi % SL) == 0) && (gi < L);

    logic [WIDTH-1:0] g_cmb;
    logic [WIDTH-1:0] p_cmb;

    for (genvar gj = 0; gj < WIDTH; gj++) begin : g_bit
      if (gi <= S && (gj % SEG_W) >= (1 << (gi - 1))) begin : g_ks
        localparam int D = 1 << (gi - 1);
        assign g_cmb[gj] = g_src[gi-1][gj] | (p_src[gi-1][gj] & g_src[gi-1][gj-D]);
        assign p_cmb[gj] = p_src[gi-1][gj] & p_src[gi-1][gj-D];
      end else if (gi > S && gi <= S + CL && (gj % SEG_W) == SEG_W - 1 &&
                   (gj / SEG_W) >= (1 << (gi - S - 1))) begin : g_xs
        // segment-level Kogge-Stone on the top bit of each segment
        localparam int D = SEG_W << (gi - S - 1);
        assign g_cmb[gj] = g_src[gi-1][gj] | (p_src[gi-1][gj] & g_src[gi-1][gj-D]);
        assign p_cmb[gj] = p_src[gi-1][gj] & p_src[gi-1][gj-D];
      end else if (gi == L && NS > 1) begin : g_fan
        // Segment tops now span HALF segments; one more combine gives the full prefix,
        // which is then fanned out to every bit of the segment that needs it.
        localparam int  SEG = gj / SEG_W;
        localparam bit  TOP = (gj % SEG_W) == SEG_W - 1;
        localparam int  K   = TOP ? SEG + 1 : SEG;
        localparam int  TK  = K * SEG_W - 1;
        localparam int  TF  = (K - 1 - HALF) * SEG_W + SEG_W - 1;
        logic seg_c;
        if (K == 0) begin : g_k0
          assign seg_c = 1'b0;
        end else if (K - 1 >= HALF) begin : g_k2
          assign seg_c = g_src[gi-1][TK] | (p_src[gi-1][TK] & g_src[gi-1][TF]);
        end else begin : g_k1
          assign seg_c = g_src[gi-1][TK];
        end
        if (TOP) begin : g_top
          assign g_cmb[gj] = seg_c;
        end else begin : g_mid
          assign g_cmb[gj] = g_src[gi-1][gj] | (p_src[gi-1][gj] & seg_c);
        end
        assign p_cmb[gj] = p_src[gi-1][gj];
      end else begin : g_pass
        assign g_cmb[gj] = g_src[gi-1][gj];
        assign p_cmb[gj] = p_src[gi-1][gj];
      end
    end

    if (REG_HERE) begin : g_pipe
      logic [WIDTH-1:0] grp_g_reg;
      logic [WIDTH-1:0] grp_p_reg;
      logic [WIDTH-1:0] prop_reg;
      logic             c0_reg;
      logic             valid_reg;

      always_ff @(posedge clk) begin
        if (!rst_n) begin
          valid_reg <= 1'b0;
        end else if (adv) begin
          valid_reg <= valid_src[gi-1];
          grp_g_reg <= g_cmb;
          grp_p_reg <= p_cmb;
          prop_reg  <= prop_src[gi-1];
          c0_reg    <= c0_src[gi-1];
        end
      end

      assign g_src[gi]     = grp_g_reg;
      assign p_src[gi]     = grp_p_reg;
      assign prop_src[gi]  = prop_reg;
      assign c0_src[gi]    = c0_reg;
      assign valid_src[gi] = valid_reg;
    end else begin : g_comb
      assign g_src[gi]     = g_cmb;
      assign p_src[gi]     = p_cmb;
      assign prop_src[gi]  = prop_src[gi-1];
      assign c0_src[gi]    = c0_src[gi-1];
      assign valid_src[gi] = valid_src[gi-1];
    end
  end

  // after the last level g_src[L][i] is the carry out of bit i
  logic [WIDTH-1:0] carry;
  logic [WIDTH-1:0] sum_next;

  assign carry    = {g_src[L][WIDTH-2:0], c0_src[L]};
  assign sum_next = prop_src[L] ^ carry;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_sum   <= '0;
      out_cout  <= 1'b0;
`ifdef PPA_FLAGS_EN
      out_zero  <= 1'b0;
      out_ovf   <= 1'b0;
`endif
    end else if (adv) begin
      out_valid <= valid_src[L];
      out_sum   <= sum_next;
      out_cout  <= g_src[L][WIDTH-1];
`ifdef PPA_FLAGS_EN
      out_zero  <= (sum_next == '0);
      out_ovf   <= carry[WIDTH-1] ^ g_src[L][WIDTH-1];
`endif
    end
  end

endmodule

// File: tb/tb_pipelined_prefix_adder.sv
// Scoreboard bench: the default 128-bit build plus 32-bit (LAT 5) and 64-bit (LAT 1) instances.
`timescale 1ns/1ps
module tb_pipelined_prefix_adder;

  localparam int LAT0 = 4;
  localparam int LAT1 = 5;
  localparam int LAT2 = 1;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst_n, in_valid, in_cin, in_sub, out_ready;
  logic [127:0] in_a, in_b;
  logic         rdy0, rdy1, rdy2, ov0, ov1, ov2, co0, co1, co2;
  logic [127:0] s0;
  logic [31:0]  s1;
  logic [63:0]  s2;
  logic         z0, z1, z2, f0, f1, f2;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int last_stall = -1;
  int beats = 0;

  typedef struct packed {
    logic [127:0] sum;
    logic         cout;
    logic         zero;
    logic         ovf;
    int           cyc;
  } exp_t;

  typedef struct packed {
    logic [127:0] a;
    logic [127:0] b;
    logic         cin;
    logic         sub;
    logic [127:0] s;
    logic         co;
    logic         z;
    logic         v;
  } vec_t;

  exp_t q0[$], q1[$], q2[$];
  vec_t vecs[12];

  always @(posedge clk) cyc <= cyc + 1;

  pipelined_prefix_adder u_dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(rdy0),
    .in_a(in_a), .in_b(in_b), .in_cin(in_cin), .in_sub(in_sub),
    .out_valid(ov0), .out_ready(out_ready), .out_sum(s0), .out_cout(co0)
`ifdef PPA_FLAGS_EN
    , .out_zero(z0), .out_ovf(f0)
`endif
  );

  pipelined_prefix_adder #(.WIDTH(32), .SEG_W(8), .STAGE_LVLS(1)) u_w32 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(rdy1),
    .in_a(in_a[31:0]), .in_b(in_b[31:0]), .in_cin(in_cin), .in_sub(in_sub),
    .out_valid(ov1), .out_ready(1'b1), .out_sum(s1), .out_cout(co1)
`ifdef PPA_FLAGS_EN
    , .out_zero(z1), .out_ovf(f1)
`endif
  );

  pipelined_prefix_adder #(.WIDTH(64), .SEG_W(64), .STAGE_LVLS(0)) u_w64 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(rdy2),
    .in_a(in_a[63:0]), .in_b(in_b[63:0]), .in_cin(in_cin), .in_sub(in_sub),
    .out_valid(ov2), .out_ready(1'b1), .out_sum(s2), .out_cout(co2)
`ifdef PPA_FLAGS_EN
    , .out_zero(z2), .out_ovf(f2)
`endif
  );

`ifndef PPA_FLAGS_EN
  assign {z0, z1, z2, f0, f1, f2} = 6'b0;
`endif

  // plain wide-integer arithmetic reference for w-bit add/subtract
  function automatic exp_t model(input logic [127:0] a, input logic [127:0] b,
                                 input logic cin, input logic sub, input int w);
    logic [128:0] m, full;
    logic [127:0] be;
    exp_t e;
    m      = (129'd1 << w) - 129'd1;
    be     = sub ? ~b : b;
    full   = ({1'b0, a} & m) + ({1'b0, be} & m) + {128'd0, sub | cin};
    e.sum  = full[127:0] & m[127:0];
    e.cout = full[w];
    e.zero = (e.sum == 128'd0);
    e.ovf  = (a[w-1] == be[w-1]) && (full[w-1] != a[w-1]);
    e.cyc  = 0;
    return e;
  endfunction

  task automatic cmp(input string tag, input exp_t e, input logic [127:0] s, input logic co,
                     input logic z, input logic v, input int lat, input bit chk_lat);
    checks++;
    if (s !== e.sum || co !== e.cout) begin
      errors++;
      $display("FAIL %s result: got sum=%h cout=%b, want sum=%h cout=%b", tag, s, co, e.sum, e.cout);
    end
`ifdef PPA_FLAGS_EN
    checks++;
    if (z !== e.zero || v !== e.ovf) begin
      errors++;
      $display("FAIL %s flags: got zero=%b ovf=%b, want zero=%b ovf=%b", tag, z, v, e.zero, e.ovf);
    end
`endif
    if (chk_lat) begin
      checks++;
      if (cyc - e.cyc != lat) begin
        errors++;
        $display("FAIL %s latency: got %0d cycles, want %0d", tag, cyc - e.cyc, lat);
      end
    end
  endtask

  task automatic chk(input string tag, input logic [127:0] act, input logic [127:0] want);
    checks++;
    if (act !== want) begin
      errors++;
      $display("FAIL %s: got %h, want %h", tag, act, want);
    end
  endtask

  // main monitor: scoreboard pop plus backpressure stability checks
  logic [127:0] hold_sum;
  logic         hold_cout;
  bit           holding = 1'b0;

  always @(negedge clk) begin
    exp_t e;
    if (!rst_n) begin
      q0.delete();
      holding = 1'b0;
    end else begin
      if (!rdy0) last_stall = cyc;
      if (holding) begin
        checks++;
        if (ov0 !== 1'b1 || s0 !== hold_sum || co0 !== hold_cout) begin
          errors++;
          $display("FAIL hold_stable: got valid=%b sum=%h cout=%b, want valid=1 sum=%h cout=%b",
                   ov0, s0, co0, hold_sum, hold_cout);
        end
      end
      holding = 1'b0;
      if (ov0 && !out_ready) begin
        checks++;
        if (rdy0 !== 1'b0) begin
          errors++;
          $display("FAIL in_ready_stall: got %b, want 0", rdy0);
        end
        holding   = 1'b1;
        hold_sum  = s0;
        hold_cout = co0;
      end
      if (ov0 && out_ready) begin
        if (q0.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL w128 unexpected: got sum=%h with no beat outstanding, want no output", s0);
        end else begin
          e = q0.pop_front();
          cmp("w128", e, s0, co0, z0, f0, LAT0, e.cyc > last_stall);
          beats++;
          $display("beat %0d: sum=%h cout=%b (issued cycle %0d, out cycle %0d)", beats, s0, co0, e.cyc, cyc);
        end
      end
    end
  end

  always @(negedge clk) begin
    exp_t e;
    if (!rst_n) begin
      q1.delete();
    end else begin
      if (ov1) begin
        if (q1.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL w32 unexpected: got sum=%h with no beat outstanding, want no output", s1);
        end else begin
          cmp("w32", q1.pop_front(), {96'd0, s1}, co1, z1, f1, LAT1, 1'b1);
        end
      end
      if (in_valid && rdy1) begin
        e = model(in_a, in_b, in_cin, in_sub, 32);
        e.cyc = cyc;
        q1.push_back(e);
      end
    end
  end

  always @(negedge clk) begin
    exp_t e;
    if (!rst_n) begin
      q2.delete();
    end else begin
      if (ov2) begin
        if (q2.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL w64 unexpected: got sum=%h with no beat outstanding, want no output", s2);
        end else begin
          cmp("w64", q2.pop_front(), {64'd0, s2}, co2, z2, f2, LAT2, 1'b1);
        end
      end
      if (in_valid && rdy2) begin
        e = model(in_a, in_b, in_cin, in_sub, 64);
        e.cyc = cyc;
        q2.push_back(e);
      end
    end
  end

  // drive one beat (called just after a rising edge), push its expectation when accepted
  task automatic send(input logic [127:0] a, input logic [127:0] b, input logic cin,
                      input logic sub, input exp_t e_in);
    exp_t e;
    bit   took;
    e    = e_in;
    took = 1'b0;
    in_valid = 1'b1;
    in_a = a;
    in_b = b;
    in_cin = cin;
    in_sub = sub;
    for (int k = 0; k < 64 && !took; k++) begin
      @(negedge clk);
      if (rdy0) begin
        e.cyc = cyc;
        q0.push_back(e);
        took = 1'b1;
      end
    end
    if (!took) begin
      checks++;
      errors++;
      $display("FAIL accept: got in_ready=0 for 64 cycles, want beat taken");
    end
    @(posedge clk);
    #1;
  endtask

  task automatic send_vec(input int i);
    exp_t e;
    e.sum  = vecs[i].s;
    e.cout = vecs[i].co;
    e.zero = vecs[i].z;
    e.ovf  = vecs[i].v;
    e.cyc  = 0;
    send(vecs[i].a, vecs[i].b, vecs[i].cin, vecs[i].sub, e);
  endtask

  task automatic send_rand();
    logic [127:0] a, b;
    logic cin, sub;
    a   = {$urandom, $urandom, $urandom, $urandom};
    b   = {$urandom, $urandom, $urandom, $urandom};
    cin = 1'($urandom_range(0, 1));
    sub = 1'($urandom_range(0, 1));
    send(a, b, cin, sub, model(a, b, cin, sub, 128));
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((q0.size() + q1.size() + q2.size()) != 0 && n < 200) begin
      @(posedge clk);
      n++;
    end
    checks++;
    if ((q0.size() + q1.size() + q2.size()) != 0) begin
      errors++;
      $display("FAIL drain: got %0d/%0d/%0d beats outstanding, want 0/0/0", q0.size(), q1.size(), q2.size());
    end
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic setv(input int i, input logic [127:0] a, input logic [127:0] b, input logic cin,
                      input logic sub, input logic [127:0] s, input logic co, input logic z, input logic v);
    vecs[i] = '{a, b, cin, sub, s, co, z, v};
  endtask

  initial begin
    logic [127:0] ones, msb;
    ones = {128{1'b1}};
    msb  = {1'b1, 127'd0};
    //        a                       b                        cin   sub   sum                                          cout  zero  ovf
    setv(0,  ones,                   128'd1,                  1'b0, 1'b0, 128'd0,                                      1'b1, 1'b1, 1'b0);
    setv(1,  128'd5,                 128'd7,                  1'b0, 1'b1, {{127{1'b1}}, 1'b0},                         1'b0, 1'b0, 1'b0);
    setv(2,  128'h1234,              128'h1234,               1'b0, 1'b1, 128'd0,                                      1'b1, 1'b1, 1'b0);
    setv(3,  128'd3,                 128'd4,                  1'b1, 1'b0, 128'd8,                                      1'b0, 1'b0, 1'b0);
    setv(4,  {64'd0, {64{1'b1}}},    128'd1,                  1'b0, 1'b0, {63'd0, 1'b1, 64'd0},                        1'b0, 1'b0, 1'b0);
    setv(5,  ones,                   128'd0,                  1'b1, 1'b0, 128'd0,                                      1'b1, 1'b1, 1'b0);
    setv(6,  msb,                    msb,                     1'b0, 1'b0, 128'd0,                                      1'b1, 1'b1, 1'b1);
    setv(7,  128'd10,                128'd3,                  1'b1, 1'b1, 128'd7,                                      1'b1, 1'b0, 1'b0);
    setv(8,  128'd0,                 128'd0,                  1'b0, 1'b0, 128'd0,                                      1'b0, 1'b1, 1'b0);
    setv(9,  128'd0,                 128'd1,                  1'b0, 1'b1, ones,                                        1'b0, 1'b0, 1'b0);
    setv(10, 128'h0123456789ABCDEF_FEDCBA9876543210, 128'h1111111111111111_1111111111111111,
                                                              1'b0, 1'b0, 128'h123456789ABCDF01_0FEDCBA987654321,     1'b0, 1'b0, 1'b0);
    setv(11, msb,                    128'd1,                  1'b0, 1'b1, {1'b0, {127{1'b1}}},                         1'b1, 1'b0, 1'b1);

    rst_n = 1'b0; in_valid = 1'b0; in_a = '0; in_b = '0; in_cin = 1'b0; in_sub = 1'b0; out_ready = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset out_valid", {127'd0, ov0}, 128'd0);
    chk("reset out_sum", s0, 128'd0);
    chk("reset out_cout", {127'd0, co0}, 128'd0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    chk("post-reset in_ready", {127'd0, rdy0}, 128'd1);
    @(posedge clk);
    #1;

    send_vec(0);
    in_valid = 1'b0;
    drain();
    send_vec(1);
    send_vec(2);
    in_valid = 1'b0;
    drain();

    fork
      begin
        for (int i = 0; i < 12; i++) send_vec(i);
        for (int i = 0; i < 1000; i++) send_rand();
        in_valid = 1'b0;
      end
      begin
        repeat (40) @(posedge clk);
        #1 out_ready = 1'b0;
        repeat (6) @(posedge clk);
        #1 out_ready = 1'b1;
      end
    join
    drain();

    for (int i = 0; i < 3; i++) send_rand();
    in_valid = 1'b0;
    rst_n = 1'b0;
    @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    chk("mid-reset w128 out_valid", {127'd0, ov0}, 128'd0);
    chk("mid-reset w32 out_valid", {127'd0, ov1}, 128'd0);
    chk("mid-reset w64 out_valid", {127'd0, ov2}, 128'd0);
    @(posedge clk);
    #1;
    send_vec(10);
    in_valid = 1'b0;
    drain();
    repeat (10) @(posedge clk);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got simulation still running at 2 ms, want finished");
    $fatal(1, "watchdog expired");
  end

endmodule
